int_controller: RTL and testbench

Interrupt controller for the RAT computer, sitting directly upstream of the control unit. It collects up to `N_SRC` asynchronous external interrupt lines and latches their rising edges as pending events. It applies a per-source mask and the global interrupt-enable (driven by the control unit's I_SET/I_CLR bits), and delivers a single registered `_INT_` request to the control unit. On the control unit's acknowledge it reports the serviced source ID and retires that event.

---
 rtl/int_ctrl_pkg.sv | 27 ++
 rtl/irq_sync_edge.sv | 38 +++
 rtl/int_controller.sv | 105 ++++++++++
 tb/tb_int_controller.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the RAT interrupt controller: default source count
// and the fixed-priority encoder used to pick the serviced source.
package int_ctrl_pkg;

    localparam int N_SRC_DEFAULT = 8;
    localparam int PRIO_W        = 16;   // widest legal source count

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } prio_t;

    // Lowest set index wins; index 0 is the highest priority source.
    function automatic prio_t prio_enc(input logic [PRIO_W-1:0] vec);
        prio_t r;
        r.valid = 1'b0;
        r.idx   = '0;
        for (int i = PRIO_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.valid = 1'b1;
                r.idx   = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer per line plus a previous-value flop; flags the
// first synchronized cycle of each rising edge.
module irq_sync_edge #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] async_in,
    output logic [W-1:0] rise
);

    logic [W-1:0] s1_q, s2_q, s3_q;
    logic [W-1:0] s1_d, s2_d, s3_d;

    // Shift the sampled lines down the synchronizer chain.
    always_comb begin
        s1_d = async_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Synchronizer and history flops; s3 clears so a line held high
    // through reset release yields exactly one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/int_controller.sv
// Interrupt controller in front of the RAT control unit: latches rising
// edges as pending events, masks them, gates with the global enable and
// reports/retires the highest-priority event on acknowledge.
module int_controller
    import int_ctrl_pkg::*;
#(
    parameter  int N_SRC = N_SRC_DEFAULT,
    localparam int ID_W  = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic [N_SRC-1:0] IRQ_IN,
    input  logic             I_SET,
    input  logic             I_CLR,
    input  logic             INT_ACK,
    input  logic [N_SRC-1:0] WR_DATA,
    input  logic             MASK_WE,
    input  logic             PCLR_WE,
    output logic             _INT_,
    output logic [ID_W-1:0]  IRQ_ID,
    output logic [N_SRC-1:0] PENDING,
    output logic             IE
);

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] ack_clr;
    prio_t            pe;
    logic [ID_W-1:0]  winner;
    logic             unused_prio;

    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q,    mask_d;
    logic             ie_q,      ie_d;
    logic             int_q,     int_d;
    logic [ID_W-1:0]  irq_id_q,  irq_id_d;

    irq_sync_edge #(.W(N_SRC)) u_sync (
        .clk      (clk),
        .rst      (RESET),
        .async_in (IRQ_IN),
        .rise     (rise)
    );

    assign eligible    = pending_q & mask_q;
    assign pe          = prio_enc(PRIO_W'(eligible));
    assign winner      = pe.idx[ID_W-1:0];
    assign unused_prio = ^pe.idx;

    // Next-state for pending/mask/enable/request/ID; a new edge always
    // beats a same-cycle clear so no event is lost.
    always_comb begin
        ack_clr   = '0;
        pending_d = pending_q;
        mask_d    = mask_q;
        ie_d      = ie_q;
        irq_id_d  = irq_id_q;
        int_d     = ie_q & (|eligible);

        if (INT_ACK && pe.valid) begin
            ack_clr  = {{(N_SRC-1){1'b0}}, 1'b1} << winner;
            irq_id_d = winner;
        end

        pending_d = pending_d & ~ack_clr;
        if (PCLR_WE) begin
            pending_d = pending_d & ~WR_DATA;
        end
        pending_d = pending_d | rise;

        if (MASK_WE) begin
            mask_d = WR_DATA;
        end

        if (I_SET) begin
            ie_d = 1'b1;
        end
        if (I_CLR || INT_ACK) begin
            ie_d = 1'b0;
        end
    end

    // Controller state registers; reset drops everything at once.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            pending_q <= '0;
            mask_q    <= '0;
            ie_q      <= 1'b0;
            int_q     <= 1'b0;
            irq_id_q  <= '0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            ie_q      <= ie_d;
            int_q     <= int_d;
            irq_id_q  <= irq_id_d;
        end
    end

    assign _INT_   = int_q;
    assign IRQ_ID  = irq_id_q;
    assign PENDING = pending_q;
    assign IE      = ie_q;

endmodule

// File: tb/tb_int_controller.sv
module tb_int_controller;

    localparam int N  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  irq_in;
    logic          i_set, i_clr, int_ack, mask_we, pclr_we;
    logic [N-1:0]  wr_data;
    logic          int_o;
    logic [IW-1:0] irq_id;
    logic [N-1:0]  pending;
    logic          ie;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [N-1:0]  m_pend, m_mask;
    logic [N-1:0]  h1, h2, h3;     // IRQ_IN sampled 1, 2, 3 edges ago
    logic          m_ie, m_int;
    logic [IW-1:0] m_id;

    int_controller #(.N_SRC(N)) dut (
        .clk     (clk),
        .RESET   (rst),
        .IRQ_IN  (irq_in),
        .I_SET   (i_set),
        .I_CLR   (i_clr),
        .INT_ACK (int_ack),
        .WR_DATA (wr_data),
        .MASK_WE (mask_we),
        .PCLR_WE (pclr_we),
        ._INT_   (int_o),
        .IRQ_ID  (irq_id),
        .PENDING (pending),
        .IE      (ie)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_ie = 1'b0; m_int = 1'b0; m_id = '0;
        h1 = '0; h2 = '0; h3 = '0;
    endtask

    // One clock edge of behaviour, computed from pre-edge values.
    task automatic model_edge();
        logic [N-1:0] elig, rise;
        int win;
        elig = m_pend & m_mask;
        win  = -1;
        for (int k = N - 1; k >= 0; k--) if (elig[k]) win = k;
        rise = h2 & ~h3;
        h3 = h2; h2 = h1; h1 = irq_in;
        m_int = m_ie && (elig != 0);
        if (int_ack && win >= 0) begin
            m_id = IW'(win);
            m_pend[win] = 1'b0;
        end
        if (pclr_we) m_pend = m_pend & ~wr_data;
        m_pend = m_pend | rise;
        if (mask_we) m_mask = wr_data;
        if (i_set) m_ie = 1'b1;
        if (i_clr || int_ack) m_ie = 1'b0;
    endtask

    task automatic compare_all();
        chk("pending", 32'(pending), 32'(m_pend));
        chk("int",     32'(int_o),   32'(m_int));
        chk("irq_id",  32'(irq_id),  32'(m_id));
        chk("ie",      32'(ie),      32'(m_ie));
    endtask

    task automatic clear_strobes();
        i_set = 0; i_clr = 0; int_ack = 0; mask_we = 0; pclr_we = 0; wr_data = '0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        clear_strobes();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        irq_in = '0;
        clear_strobes();
        do_reset();
        compare_all();
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_int",     32'(int_o),   32'h0);

        // single source, full timing
        wr_data = 8'hFF; mask_we = 1; i_set = 1; step();
        irq_in[3] = 1'b1; step();            // E1
        step();                              // E2
        chk("e2_pending", 32'(pending), 32'h00);
        step();                              // E3
        chk("e3_pending", 32'(pending), 32'h08);
        chk("e3_int", 32'(int_o), 32'h0);
        irq_in[3] = 1'b0; step();            // E4
        chk("e4_int", 32'(int_o), 32'h1);
        int_ack = 1; step();                 // A
        chk("ack_id", 32'(irq_id), 32'd3);
        chk("ack_pending", 32'(pending), 32'h0);
        chk("ack_ie", 32'(ie), 32'h0);
        step();
        chk("ack_int_fall", 32'(int_o), 32'h0);

        // priority between simultaneous sources
        i_set = 1; irq_in = 8'h24; steps(3);
        chk("two_pending", 32'(pending), 32'h24);
        irq_in = '0; step();
        chk("two_int", 32'(int_o), 32'h1);
        int_ack = 1; step();
        chk("first_id", 32'(irq_id), 32'd2);
        chk("first_pend", 32'(pending), 32'h20);
        i_set = 1; step();
        step();
        int_ack = 1; step();
        chk("second_id", 32'(irq_id), 32'd5);

        // masked source still latches, requests after unmask
        wr_data = 8'h00; mask_we = 1; i_set = 1; step();
        irq_in[1] = 1'b1; steps(4);
        chk("masked_pend", 32'(pending), 32'h02);
        chk("masked_int", 32'(int_o), 32'h0);
        irq_in[1] = 1'b0;
        wr_data = 8'h02; mask_we = 1; step();
        chk("unmask_int0", 32'(int_o), 32'h0);
        step();
        chk("unmask_int1", 32'(int_o), 32'h1);

        // clear and set of the same bit in one cycle: set wins
        wr_data = 8'h02; pclr_we = 1; step();
        chk("pclr", 32'(pending), 32'h00);
        irq_in[1] = 1'b1; steps(2);
        wr_data = 8'h02; pclr_we = 1; step();
        chk("set_wins", 32'(pending[1]), 32'h1);
        irq_in[1] = 1'b0;

        // I_SET with I_CLR, ack with nothing eligible
        i_set = 1; i_clr = 1; step();
        chk("clr_wins", 32'(ie), 32'h0);
        wr_data = 8'hFF; pclr_we = 1; step();
        int_ack = 1; step();
        chk("empty_ack_id", 32'(irq_id), 32'd5);

        // line held high through reset release yields one event
        irq_in[0] = 1'b1;
        do_reset();
        steps(4);
        chk("held_one", 32'(pending), 32'h01);
        wr_data = 8'h01; pclr_we = 1; step();
        steps(5);
        chk("held_no_more", 32'(pending), 32'h00);
        irq_in[0] = 1'b0;

        // asynchronous reset mid-request
        wr_data = 8'hFF; mask_we = 1; i_set = 1; step();
        irq_in[6] = 1'b1; steps(4);
        chk("pre_rst_int", 32'(int_o), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_int", 32'(int_o), 32'h0);
        chk("async_pend", 32'(pending), 32'h0);
        chk("async_ie", 32'(ie), 32'h0);
        irq_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++)
                if ($urandom_range(0, 5) == 0) irq_in[k] = ~irq_in[k];
            wr_data = N'($urandom);
            mask_we = ($urandom_range(0, 9) == 0);
            pclr_we = ($urandom_range(0, 7) == 0);
            i_set   = ($urandom_range(0, 3) == 0);
            i_clr   = ($urandom_range(0, 11) == 0);
            int_ack = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
